// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the fp_i2f round-robin arbiter.
package fp_arb_pkg;

  localparam int unsigned DefNReq   = 4;
  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefMaxOut = 8;
  localparam int unsigned MaxReq    = 8;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StHalt} arb_state_e;

  // Returns {hit, index} of the first valid requester at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_winner(input logic [MaxReq-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int unsigned       n);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if (k < n && !res[3] && valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight conversion.
module fp_arb_tag_fifo
  import fp_arb_pkg::*;
#(
  parameter int unsigned Depth = DefMaxOut,
  parameter int unsigned Width = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clock,
  input  logic            clock_sreset,
  input  logic            push,
  input  logic [Width-1:0] push_data,
  input  logic            pop,
  output logic [Width-1:0] pop_data,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign count    = count_q;

endmodule

// File: rtl/fp_i2f_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_i2f converter among N_REQ requesters.
// Define FP_I2F_ARB_ERR_EN to add a sticky err output for results arriving with no tag.
module fp_i2f_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MAX_OUT = DefMaxOut,
  parameter int unsigned ID_W    = $clog2(N_REQ),
  localparam int unsigned CntW   = $clog2(MAX_OUT + 1)
) (
  input  logic                   clock,
  input  logic                   clock_sreset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   cvt_valid,
  output logic [WIDTH-1:0]       cvt_dataa,
  input  logic                   cvt_result_valid,
  input  logic [WIDTH-1:0]       cvt_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   drain,
  output logic                   drain_done,
  output logic [CntW-1:0]        outstanding
`ifdef FP_I2F_ARB_ERR_EN
  ,
  output logic                   err
`endif
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [MaxReq-1:0] valid_ext;
  logic [2:0]        ptr_ext;
  logic [3:0]        win;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   win_id, pop_id;
  logic              blocked, push, pop, fifo_empty, fifo_full;
  logic [CntW-1:0]   count, count_nxt;

  logic              cvt_valid_q, cvt_valid_d;
  logic [WIDTH-1:0]  cvt_dataa_q, cvt_dataa_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  // Credit is checked against the pre-pop count; drain blocks in the same cycle.
  always_comb begin
    valid_ext = '0;
    valid_ext[N_REQ-1:0] = req_valid;
    ptr_ext = '0;
    ptr_ext[ID_W-1:0] = rr_ptr_q;
    blocked = fifo_full | drain | (state_q == StDrain) | (state_q == StHalt);
    win = rr_winner(valid_ext, ptr_ext, N_REQ);
    grant = '0;
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!blocked && win[3] && (win[2:0] == 3'(i))) begin
        grant[i] = 1'b1;
        win_id   = ID_W'(i);
      end
    end
  end

  assign req_ready = grant;
  assign push      = |(grant & req_valid);
  assign pop       = cvt_result_valid & ~fifo_empty;
  assign count_nxt = count + CntW'(push) - CntW'(pop);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cvt_valid_d = push;
    cvt_dataa_d = '0;
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (push) rr_ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) cvt_dataa_d = req_data[i*WIDTH +: WIDTH];
    end
    if (pop) begin
      rsp_valid_d[pop_id] = 1'b1;
      rsp_id_d            = pop_id;
      rsp_data_d          = cvt_result;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (drain) state_d = StDrain; else if (push) state_d = StBusy;
      StBusy:  if (drain) state_d = StDrain; else if (count_nxt == '0) state_d = StIdle;
      StDrain: if (count == '0) state_d = StHalt;
      StHalt:  if (!drain) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cvt_valid_q <= 1'b0;
      cvt_dataa_q <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cvt_valid_q <= cvt_valid_d;
      cvt_dataa_q <= cvt_dataa_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cvt_valid  = cvt_valid_q;
  assign cvt_dataa  = cvt_dataa_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign drain_done = (state_q == StHalt);
  assign outstanding = count;

`ifdef FP_I2F_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) err_q <= 1'b0;
    else              err_q <= err_q | (cvt_result_valid & fifo_empty);
  end
  assign err = err_q;
`endif

  fp_arb_tag_fifo #(
    .Depth(MAX_OUT),
    .Width(ID_W)
  ) u_tag_fifo (
    .clock       (clock),
    .clock_sreset(clock_sreset),
    .push        (push),
    .push_data   (win_id),
    .pop         (pop),
    .pop_data    (pop_id),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .count       (count)
  );

endmodule

// File: doc/fp_i2f_arbiter.md
# fp_i2f_arbiter

Round-robin arbiter that shares one pipelined integer-to-float converter (fp_i2f) among N_REQ requesters. It grants at most one conversion per cycle and tags each issue with the requester ID in an in-order tag FIFO. It steers each converter result back to its owner, and bounds in-flight work with a credit limit. It sits between the inference datapath's conversion clients and the single shared fp_i2f instance, which is external to this block.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, integer input and float result width (matches fp_i2f WIDTH)
- MAX_OUT, 8, maximum outstanding conversions; equals tag FIFO depth (power of 2)
- ID_W, $clog2(N_REQ), requester ID width
- clock  in  1  single clock, rising edge
- clock_sreset  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester request
- req_data  in  N_REQ*WIDTH  signed integer operand; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot grant; handshake occurs when req_valid[i] and req_ready[i] are both high
- cvt_valid  out  1  drives fp_i2f data_valid
- cvt_dataa  out  WIDTH  drives fp_i2f dataa
- cvt_result_valid  in  1  from fp_i2f result_valid
- cvt_result  in  WIDTH  from fp_i2f result
- rsp_valid  out  N_REQ  one-hot result strobe
- rsp_id  out  ID_W  owner of rsp_data
- rsp_data  out  WIDTH  float result
- drain  in  1  level; stops new grants
- drain_done  out  1  high when draining is complete
- outstanding  out  $clog2(MAX_OUT+1)  in-flight count

## Operation
- Arbitration is combinational from req_valid, rr_ptr, credit and state.
  - The winner is the lowest index i >= rr_ptr (wrapping) with req_valid[i] high.
  - req_ready is the winner's one-hot, or 0 when blocked.
  - Blocked means outstanding == MAX_OUT, or state is DRAIN or HALT.
- On a handshake with requester i:
  - rr_ptr <= (i+1) mod N_REQ.
  - Push i to the tag FIFO; outstanding increments.
  - cvt_valid <= 1 and cvt_dataa <= req_data slice i (registered).
- With no handshake: cvt_valid <= 0 and cvt_dataa <= 0.
- On cvt_result_valid with a non-empty FIFO:
  - Pop tag t; outstanding decrements.
  - Registered outputs: rsp_valid <= 1<<t, rsp_id <= t, rsp_data <= cvt_result.
- A push and a pop in the same cycle leave outstanding unchanged. Credit is checked against the pre-pop count; there is no same-cycle reuse.
- The converter has no backpressure and responses are not stallable. Requesters must accept rsp_valid unconditionally.
- cvt_result_valid with an empty FIFO is dropped: no rsp_valid and no state change.
- FSM:
  - IDLE: outstanding == 0. Goes to BUSY on a handshake, or to DRAIN when drain is high.
  - BUSY: goes to IDLE when outstanding reaches 0 with no push, or to DRAIN when drain is high.
  - DRAIN: no grants. Goes to HALT when outstanding == 0.
  - HALT: drain_done = 1, no grants. Goes to IDLE when drain is low.
- Reset values: all outputs 0, rr_ptr 0, FIFO empty, state IDLE.
- Reset mid-operation discards all tags. Converter results that arrive afterwards are dropped; the converter must be reset together with this block.

## Timing
- Handshake at cycle t gives cvt_valid at t+1.
- With fp_i2f latency L, result_valid arrives at t+1+L and rsp_valid at t+2+L.
- Sustained throughput is one conversion per cycle while credit is available. Full rate therefore needs MAX_OUT >= L+2.
- drain asserted in cycle t blocks grants in cycle t itself (combinational), even before the state register changes.
- drain_done rises the cycle after outstanding reaches 0 in DRAIN.

## Configuration
- FP_I2F_ARB_ERR_EN defined:
  - Adds output port err (1 bit, reset 0).
  - err is sticky and is set by cvt_result_valid arriving with an empty tag FIFO.
  - err is cleared only by reset.
- FP_I2F_ARB_ERR_EN undefined: no err port; such results are silently dropped.

## Structure
- A shared package, fp_arb_pkg, holds:
  - the state enum (IDLE, BUSY, DRAIN, HALT);
  - a function that computes the round-robin winner;
  - default parameter constants.
- One sub-module: fp_arb_tag_fifo, a synchronous FIFO of MAX_OUT x ID_W with push, pop, empty, full and count. Its count drives outstanding.

## Test plan
- Single requester 0, WIDTH=16, L=3, operands -255, -128, -1, 0, 1, 128, 255 in turn:
  - rsp_data = 0xDBF8, 0xD800, 0xBC00, 0x0000, 0x3C00, 0x5800, 0x5BF8;
  - rsp_id = 0, each response 5 cycles after its handshake.
- All 4 requesters hold req_valid with operand = index+1:
  - grants go 0, 1, 2, 3, 0, ... back-to-back;
  - responses return in the same order with 0x3C00, 0x4000, 0x4200, 0x4400.
- MAX_OUT=2 with L=3 and continuous requests:
  - req_ready drops after 2 grants; outstanding never exceeds 2;
  - no response is lost.
- Drain while 3 conversions are in flight:
  - req_ready is 0 from the drain cycle; 3 responses still arrive;
  - drain_done rises the cycle after the last pop and falls after drain is deasserted.
- Reset asserted with 2 conversions in flight:
  - all outputs are 0 immediately (asynchronous reset);
  - stray converter results produce no rsp_valid;
  - err = 1 when FP_I2F_ARB_ERR_EN is defined.
- Push and pop in the same cycle at outstanding == MAX_OUT-1: the count holds, and the FIFO order stays intact.
